// File: rtl/mtd_pkg.sv
// -----------------------------------------------------------------------------
// mtd_pkg
// Shared definitions for the multi-channel hysteresis threshold detector:
//   - per-channel FSM state encoding
//   - default arming/release thresholds applied at reset
// -----------------------------------------------------------------------------
package mtd_pkg;

    typedef enum logic [1:0] {
        ST_ARMED = 2'd0,
        ST_HIGH  = 2'd1,
        ST_HOLD  = 2'd2
    } mtd_state_t;

    // Reset thresholds of the single-channel detector this block replaces;
    // truncated to the sample width where they are applied.
    localparam int unsigned THR_HIGH_DEFAULT = 800;
    localparam int unsigned THR_LOW_DEFAULT  = 400;

endpackage

// File: rtl/mtd_channel.sv
// -----------------------------------------------------------------------------
// mtd_channel
// One hysteresis detector channel: ARMED -> HIGH on a qualified sample at or
// above thr_high, HIGH -> HOLD (or straight to ARMED when hold_cycles is 0) on
// a qualified sample at or below thr_low, HOLD counts down to re-arm.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   sample        channel sample (unsigned)
//   sample_valid  sample qualifier; unqualified samples never cause transitions
//   thr_high      arming threshold (inclusive)
//   thr_low       release threshold (inclusive)
//   hold_cycles   hold-off length loaded on release
//   fire          combinational: arming crossing happens at the coming edge
//   detect        registered one-cycle pulse following an arming crossing
// -----------------------------------------------------------------------------
module mtd_channel
    import mtd_pkg::*;
#(
    parameter int unsigned CNTR_WIDTH = 10,
    parameter int unsigned HOLD_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CNTR_WIDTH-1:0] sample,
    input  logic                  sample_valid,
    input  logic [CNTR_WIDTH-1:0] thr_high,
    input  logic [CNTR_WIDTH-1:0] thr_low,
    input  logic [HOLD_WIDTH-1:0] hold_cycles,
    output logic                  fire,
    output logic                  detect
);

    mtd_state_t            state_q;
    mtd_state_t            state_d;
    logic [HOLD_WIDTH-1:0] hold_q;
    logic [HOLD_WIDTH-1:0] hold_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ARMED;
            hold_q  <= '0;
            detect  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            detect  <= fire;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        fire    = 1'b0;
        case (state_q)
            ST_ARMED: begin
                if (sample_valid && (sample >= thr_high)) begin
                    state_d = ST_HIGH;
                    fire    = 1'b1;
                end
            end
            ST_HIGH: begin
                if (sample_valid && (sample <= thr_low)) begin
                    if (hold_cycles == '0) begin
                        state_d = ST_ARMED;
                    end else begin
                        state_d = ST_HOLD;
                        hold_d  = hold_cycles;
                    end
                end
            end
            ST_HOLD: begin
                // Samples are ignored here; the count runs every cycle and the
                // channel re-arms on the edge after the count reaches 1.
                if (hold_q <= HOLD_WIDTH'(1)) begin
                    state_d = ST_ARMED;
                end else begin
                    hold_d = hold_q - HOLD_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_ARMED;
            end
        endcase
    end

endmodule

// File: rtl/multi_threshold_detect.sv
// -----------------------------------------------------------------------------
// multi_threshold_detect
// N_CH-channel hysteresis threshold detector with runtime thresholds, hold-off,
// first-event record and per-channel detect timestamps.
//
// Build option:
//   MTD_TIMESTAMP_EN  defined: free-running timestamp counter and per-channel
//                     ts capture; undefined: ts is tied to 0.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   cntr          packed samples, channel i at [i*CNTR_WIDTH +: CNTR_WIDTH]
//   cntr_valid    per-channel sample qualifier
//   cfg_load      latch thr_high/thr_low/hold_cycles (effective next cycle)
//   thr_high      arming threshold
//   thr_low       release threshold
//   hold_cycles   hold-off length in clk cycles
//   evt_clr       clear first-event record (a same-cycle detect wins)
//   detect        one-cycle pulse per channel per arming crossing
//   first_valid   first-event record holds data
//   first_ch      lowest-index channel of the first detect since clear
//   ts            packed per-channel timestamp of the last detect
// -----------------------------------------------------------------------------
module multi_threshold_detect
    import mtd_pkg::*;
#(
    parameter  int unsigned CNTR_WIDTH = 10,
    parameter  int unsigned N_CH       = 4,
    parameter  int unsigned HOLD_WIDTH = 8,
    parameter  int unsigned TS_WIDTH   = 16,
    localparam int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CH*CNTR_WIDTH-1:0] cntr,
    input  logic [N_CH-1:0]            cntr_valid,
    input  logic                       cfg_load,
    input  logic [CNTR_WIDTH-1:0]      thr_high,
    input  logic [CNTR_WIDTH-1:0]      thr_low,
    input  logic [HOLD_WIDTH-1:0]      hold_cycles,
    input  logic                       evt_clr,
    output logic [N_CH-1:0]            detect,
    output logic                       first_valid,
    output logic [CH_W-1:0]            first_ch,
    output logic [N_CH*TS_WIDTH-1:0]   ts
);

    localparam logic [CNTR_WIDTH-1:0] THR_HIGH_RST = CNTR_WIDTH'(THR_HIGH_DEFAULT);
    localparam logic [CNTR_WIDTH-1:0] THR_LOW_RST  = CNTR_WIDTH'(THR_LOW_DEFAULT);

    logic [CNTR_WIDTH-1:0] thr_high_q;
    logic [CNTR_WIDTH-1:0] thr_low_q;
    logic [HOLD_WIDTH-1:0] hold_q;
    logic [N_CH-1:0]       fire;
    logic                  any_fire;
    logic [CH_W-1:0]       first_idx;

    // Configuration registers
    always_ff @(posedge clk) begin
        if (rst) begin
            thr_high_q <= THR_HIGH_RST;
            thr_low_q  <= THR_LOW_RST;
            hold_q     <= '0;
        end else if (cfg_load) begin
            thr_high_q <= thr_high;
            thr_low_q  <= thr_low;
            hold_q     <= hold_cycles;
        end
    end

    // Channel FSMs
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        mtd_channel #(
            .CNTR_WIDTH (CNTR_WIDTH),
            .HOLD_WIDTH (HOLD_WIDTH)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .sample       (cntr[g*CNTR_WIDTH +: CNTR_WIDTH]),
            .sample_valid (cntr_valid[g]),
            .thr_high     (thr_high_q),
            .thr_low      (thr_low_q),
            .hold_cycles  (hold_q),
            .fire         (fire[g]),
            .detect       (detect[g])
        );
    end

    // Lowest-index firing channel: scan downward so the lowest hit wins.
    always_comb begin
        any_fire  = |fire;
        first_idx = '0;
        for (int unsigned i = N_CH; i > 0; i--) begin
            if (fire[i-1]) begin
                first_idx = CH_W'(i - 1);
            end
        end
    end

    // First-event record; a detect in the clear cycle re-latches immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            first_valid <= 1'b0;
            first_ch    <= '0;
        end else if (any_fire && (!first_valid || evt_clr)) begin
            first_valid <= 1'b1;
            first_ch    <= first_idx;
        end else if (evt_clr) begin
            first_valid <= 1'b0;
        end
    end

`ifdef MTD_TIMESTAMP_EN
    logic [TS_WIDTH-1:0]      ts_cnt;
    logic [N_CH*TS_WIDTH-1:0] ts_q;

    // Captures use the counter value before this edge's increment, so all
    // channels firing together record the same stamp.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_cnt <= '0;
            ts_q   <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_WIDTH'(1);
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (fire[i]) begin
                    ts_q[i*TS_WIDTH +: TS_WIDTH] <= ts_cnt;
                end
            end
        end
    end

    assign ts = ts_q;
`else
    assign ts = '0;
`endif

endmodule
